// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - shared SAP-1 opcodes, T-state codes and control-word bit indices
package sap1_pkg;

    // One-hot controller states; HALT is absorbing until reset
    typedef enum logic [7:0] {
        ST_IDLE = 8'b0000_0001,
        ST_T1   = 8'b0000_0010,
        ST_T2   = 8'b0000_0100,
        ST_T3   = 8'b0000_1000,
        ST_T4   = 8'b0001_0000,
        ST_T5   = 8'b0010_0000,
        ST_T6   = 8'b0100_0000,
        ST_HALT = 8'b1000_0000
    } state_t;

    // Opcodes live in IR[7:4]
    localparam logic [3:0] OPC_LDA = 4'b0000;
    localparam logic [3:0] OPC_ADD = 4'b0001;
    localparam logic [3:0] OPC_SUB = 4'b0010;
    localparam logic [3:0] OPC_OUT = 4'b1110;
    localparam logic [3:0] OPC_HLT = 4'b1111;

    // Binary T-state codes presented on t_state_o (IDLE and HALT both read 0)
    localparam logic [2:0] TS_IDLE = 3'd0;
    localparam logic [2:0] TS_T1   = 3'd1;
    localparam logic [2:0] TS_T2   = 3'd2;
    localparam logic [2:0] TS_T3   = 3'd3;
    localparam logic [2:0] TS_T4   = 3'd4;
    localparam logic [2:0] TS_T5   = 3'd5;
    localparam logic [2:0] TS_T6   = 3'd6;

    // Control-word bit positions
    localparam int CW_PC_INC   = 0;
    localparam int CW_PC_OUT   = 1;
    localparam int CW_MAR_LOAD = 2;
    localparam int CW_RAM_OUT  = 3;
    localparam int CW_IR_LOAD  = 4;
    localparam int CW_IR_OUT   = 5;
    localparam int CW_A_LOAD   = 6;
    localparam int CW_A_OUT    = 7;
    localparam int CW_B_LOAD   = 8;
    localparam int CW_ALU_OUT  = 9;
    localparam int CW_OUT_LOAD = 10;
    localparam int CW_SUB_EN   = 11;
    localparam int CW_W        = 12;

endpackage

// File: rtl/sap1_step_gen.sv
// rtl/sap1_step_gen.sv - single-step edge detect producing the advance enable
module sap1_step_gen (
    input  logic clk_i,
    input  logic rst_i,
    input  logic step_mode_i,
    input  logic step_i,
    output logic adv_o
);

    logic step_q;

    // Remember last cycle's step level so a held button yields one advance
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step_i;
        end
    end

    assign adv_o = step_mode_i ? (step_i & ~step_q) : 1'b1;

endmodule

// File: rtl/sap1_ctrl_seq.sv
// rtl/sap1_ctrl_seq.sv - SAP-1 T-state ring and control-word decoder with run/halt/step
module sap1_ctrl_seq
    import sap1_pkg::*;
#(
    parameter bit EARLY_END = 1'b1,
    parameter int OPC_W     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [OPC_W-1:0] opcode_i,
    input  logic             run_i,
    input  logic             step_mode_i,
    input  logic             step_i,
    output logic             pc_inc_o,
    output logic             pc_out_o,
    output logic             mar_load_o,
    output logic             ram_out_o,
    output logic             ir_load_o,
    output logic             ir_out_o,
    output logic             a_load_o,
    output logic             a_out_o,
    output logic             b_load_o,
    output logic             alu_out_o,
    output logic             out_load_o,
    output logic             sub_en_o,
    output logic [2:0]       t_state_o,
    output logic             halted_o
);

    state_t            state_q;
    logic              adv;
    logic              is_lda, is_add, is_sub, is_out, is_hlt;
    logic              is_mem, is_alu;
    logic [CW_W-1:0]   cw;
    state_t            next_ins;

    sap1_step_gen u_step_gen (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .step_mode_i (step_mode_i),
        .step_i      (step_i),
        .adv_o       (adv)
    );

    assign is_lda = (opcode_i == OPC_W'(OPC_LDA));
    assign is_add = (opcode_i == OPC_W'(OPC_ADD));
    assign is_sub = (opcode_i == OPC_W'(OPC_SUB));
    assign is_out = (opcode_i == OPC_W'(OPC_OUT));
    assign is_hlt = (opcode_i == OPC_W'(OPC_HLT));
    assign is_mem = is_lda | is_add | is_sub;
    assign is_alu = is_add | is_sub;

    // run_i is only sampled when a new instruction would start
    assign next_ins = run_i ? ST_T1 : ST_IDLE;

    // T-state ring: moves only on enabled edges, HALT holds until reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else if (adv) begin
            unique case (state_q)
                ST_IDLE: state_q <= next_ins;
                ST_T1:   state_q <= ST_T2;
                ST_T2:   state_q <= ST_T3;
                ST_T3:   state_q <= ST_T4;
                ST_T4: begin
                    if (is_hlt)                      state_q <= ST_HALT;
                    else if (EARLY_END && !is_mem)   state_q <= next_ins;
                    else                             state_q <= ST_T5;
                end
                ST_T5: begin
                    if (EARLY_END && !is_alu)        state_q <= next_ins;
                    else                             state_q <= ST_T6;
                end
                ST_T6:   state_q <= next_ins;
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Control word decode from current state and opcode, before step gating
    always_comb begin
        cw = '0;
        unique case (state_q)
            ST_T1: begin
                cw[CW_PC_OUT]   = 1'b1;
                cw[CW_MAR_LOAD] = 1'b1;
            end
            ST_T2: cw[CW_PC_INC] = 1'b1;
            ST_T3: begin
                cw[CW_RAM_OUT] = 1'b1;
                cw[CW_IR_LOAD] = 1'b1;
            end
            ST_T4: begin
                if (is_mem) begin
                    cw[CW_IR_OUT]   = 1'b1;
                    cw[CW_MAR_LOAD] = 1'b1;
                end else if (is_out) begin
                    cw[CW_A_OUT]    = 1'b1;
                    cw[CW_OUT_LOAD] = 1'b1;
                end
            end
            ST_T5: begin
                if (is_lda) begin
                    cw[CW_RAM_OUT] = 1'b1;
                    cw[CW_A_LOAD]  = 1'b1;
                end else if (is_alu) begin
                    cw[CW_RAM_OUT] = 1'b1;
                    cw[CW_B_LOAD]  = 1'b1;
                end
            end
            ST_T6: begin
                if (is_alu) begin
                    cw[CW_ALU_OUT] = 1'b1;
                    cw[CW_A_LOAD]  = 1'b1;
                    cw[CW_SUB_EN]  = is_sub;
                end
            end
            default: cw = '0;
        endcase
    end

    // Binary T-state view for the debug display
    always_comb begin
        t_state_o = TS_IDLE;
        unique case (state_q)
            ST_T1:   t_state_o = TS_T1;
            ST_T2:   t_state_o = TS_T2;
            ST_T3:   t_state_o = TS_T3;
            ST_T4:   t_state_o = TS_T4;
            ST_T5:   t_state_o = TS_T5;
            ST_T6:   t_state_o = TS_T6;
            default: t_state_o = TS_IDLE;
        endcase
    end

    // Strobes fire only in enabled cycles; the ALU mode select is held for the whole dwell
    assign pc_inc_o   = cw[CW_PC_INC]   & adv;
    assign pc_out_o   = cw[CW_PC_OUT]   & adv;
    assign mar_load_o = cw[CW_MAR_LOAD] & adv;
    assign ram_out_o  = cw[CW_RAM_OUT]  & adv;
    assign ir_load_o  = cw[CW_IR_LOAD]  & adv;
    assign ir_out_o   = cw[CW_IR_OUT]   & adv;
    assign a_load_o   = cw[CW_A_LOAD]   & adv;
    assign a_out_o    = cw[CW_A_OUT]    & adv;
    assign b_load_o   = cw[CW_B_LOAD]   & adv;
    assign alu_out_o  = cw[CW_ALU_OUT]  & adv;
    assign out_load_o = cw[CW_OUT_LOAD] & adv;
    assign sub_en_o   = cw[CW_SUB_EN];
    assign halted_o   = (state_q == ST_HALT);

endmodule

// File: tb/tb_sap1_ctrl_seq.sv
// tb/tb_sap1_ctrl_seq.sv - randomized check of two controller builds against a behavioural model
module tb_sap1_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       step_mode;
    logic       step;
    logic [3:0] opc [2];

    logic        pc_inc [2], pc_out [2], mar_load [2], ram_out [2], ir_load [2], ir_out [2];
    logic        a_load [2], a_out [2], b_load [2], alu_out [2], out_load [2], sub_en [2];
    logic [2:0]  ts [2];
    logic        hl [2];
    logic [11:0] w [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: T number (0 = idle), halted flag, last step level
    int   mt [2];
    bit   mh [2];
    bit   mstep_q;
    bit   madv;
    int   hcnt;

    always #5 clk = ~clk;

    sap1_ctrl_seq #(.EARLY_END(1'b1), .OPC_W(4)) u_dut_early (
        .clk_i(clk), .rst_i(rst), .opcode_i(opc[0]), .run_i(run),
        .step_mode_i(step_mode), .step_i(step),
        .pc_inc_o(pc_inc[0]), .pc_out_o(pc_out[0]), .mar_load_o(mar_load[0]),
        .ram_out_o(ram_out[0]), .ir_load_o(ir_load[0]), .ir_out_o(ir_out[0]),
        .a_load_o(a_load[0]), .a_out_o(a_out[0]), .b_load_o(b_load[0]),
        .alu_out_o(alu_out[0]), .out_load_o(out_load[0]), .sub_en_o(sub_en[0]),
        .t_state_o(ts[0]), .halted_o(hl[0])
    );

    sap1_ctrl_seq #(.EARLY_END(1'b0), .OPC_W(4)) u_dut_full (
        .clk_i(clk), .rst_i(rst), .opcode_i(opc[1]), .run_i(run),
        .step_mode_i(step_mode), .step_i(step),
        .pc_inc_o(pc_inc[1]), .pc_out_o(pc_out[1]), .mar_load_o(mar_load[1]),
        .ram_out_o(ram_out[1]), .ir_load_o(ir_load[1]), .ir_out_o(ir_out[1]),
        .a_load_o(a_load[1]), .a_out_o(a_out[1]), .b_load_o(b_load[1]),
        .alu_out_o(alu_out[1]), .out_load_o(out_load[1]), .sub_en_o(sub_en[1]),
        .t_state_o(ts[1]), .halted_o(hl[1])
    );

    // Bit order: 0 pc_inc, 1 pc_out, 2 mar_load, 3 ram_out, 4 ir_load, 5 ir_out,
    // 6 a_load, 7 a_out, 8 b_load, 9 alu_out, 10 out_load, 11 sub_en
    for (genvar g = 0; g < 2; g++) begin : g_pack
        assign w[g] = {sub_en[g], out_load[g], alu_out[g], b_load[g], a_out[g], a_load[g],
                       ir_out[g], ir_load[g], ram_out[g], mar_load[g], pc_out[g], pc_inc[g]};
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Ungated control word straight from the instruction table
    function automatic logic [11:0] table_word(int t, logic [3:0] op);
        logic [11:0] r;
        r = '0;
        case (t)
            1: begin r[1] = 1'b1; r[2] = 1'b1; end
            2: r[0] = 1'b1;
            3: begin r[3] = 1'b1; r[4] = 1'b1; end
            4: begin
                if (op <= 4'd2)       begin r[5] = 1'b1; r[2] = 1'b1; end
                else if (op == 4'd14) begin r[7] = 1'b1; r[10] = 1'b1; end
            end
            5: begin
                if (op == 4'd0)                    begin r[3] = 1'b1; r[6] = 1'b1; end
                else if (op == 4'd1 || op == 4'd2) begin r[3] = 1'b1; r[8] = 1'b1; end
            end
            6: begin
                if (op == 4'd1 || op == 4'd2) begin r[9] = 1'b1; r[6] = 1'b1; end
                if (op == 4'd2) r[11] = 1'b1;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Last execute state of an instruction
    function automatic int last_t(logic [3:0] op, bit ee);
        if (!ee) return 6;
        if (op == 4'd0) return 5;
        if (op == 4'd1 || op == 4'd2) return 6;
        return 4;
    endfunction

    function automatic logic [3:0] pick_op();
        int r;
        r = $urandom_range(0, 19);
        if (r < 4)  return 4'd0;
        if (r < 8)  return 4'd1;
        if (r < 12) return 4'd2;
        if (r < 15) return 4'd14;
        if (r < 16) return 4'd15;
        return 4'($urandom_range(3, 13));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mt[i] = 0;
            mh[i] = 1'b0;
        end
        mstep_q = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_word"}, int'(w[i]), 0);
            check({tag, "_tstate"}, int'(ts[i]), 0);
            check({tag, "_halted"}, int'(hl[i]), 0);
        end
    endtask

    task automatic check_outputs();
        logic [11:0] e;
        madv = step_mode ? (step & ~mstep_q) : 1'b1;
        for (int i = 0; i < 2; i++) begin
            e = mh[i] ? 12'h000 : table_word(mt[i], opc[i]);
            if (!madv) e = e & 12'h800;
            check(i == 0 ? "word_ee1" : "word_ee0", int'(w[i]), int'(e));
            check(i == 0 ? "tstate_ee1" : "tstate_ee0", int'(ts[i]), mh[i] ? 0 : mt[i]);
            check(i == 0 ? "halted_ee1" : "halted_ee0", int'(hl[i]), int'(mh[i]));
            check("one_bus_driver", int'($countones(w[i] & 12'h2AA) <= 1), 1);
        end
    endtask

    task automatic model_edge();
        madv = step_mode ? (step & ~mstep_q) : 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (!mh[i] && madv) begin
                if (mt[i] == 0)                          mt[i] = run ? 1 : 0;
                else if (mt[i] <= 3)                     mt[i] = mt[i] + 1;
                else if (mt[i] == 4 && opc[i] == 4'd15) begin mh[i] = 1'b1; mt[i] = 0; end
                else if (mt[i] == last_t(opc[i], i == 0)) mt[i] = run ? 1 : 0;
                else                                     mt[i] = mt[i] + 1;
            end
        end
        mstep_q = step;
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b1;
        step_mode = 1'b0;
        step = 1'b0;
        opc[0] = 4'd2;
        opc[1] = 4'd14;
        hcnt = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) step_mode = (c >= 256) && ($urandom_range(0, 2) == 0);
            if (step_mode) begin
                if ($urandom_range(0, 3) == 0) step = ~step;
            end else begin
                step = 1'($urandom_range(0, 1));
            end
            run = ($urandom_range(0, 11) != 0);
            for (int i = 0; i < 2; i++)
                if (mh[i] || mt[i] <= 3) opc[i] = pick_op();
            #1;
            check_outputs();
            hcnt = (mh[0] && mh[1]) ? hcnt + 1 : 0;
            if ($urandom_range(0, 149) == 0 || hcnt > 20) begin
                #1 rst = 1'b1;
                #1;
                check_zero("async_reset");
                rst = 1'b0;
                model_reset();
                hcnt = 0;
            end
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
